// File: rtl/lsu_arbiter.sv
// Two-master round-robin arbiter and sequencer in front of the single-port LSU.
// Each access is one registered ACCESS cycle, followed by one RESP cycle that carries the ack.
module lsu_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic              i_m0_lock,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic [2:0]        i_m0_funct3,
  output logic              o_m0_gnt,
  output logic              o_m0_ack,
  output logic [DATA_W-1:0] o_m0_rdata,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic              i_m1_lock,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  input  logic [2:0]        i_m1_funct3,
  output logic              o_m1_gnt,
  output logic              o_m1_ack,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [ADDR_W-1:0] o_lsu_addr,
  output logic [DATA_W-1:0] o_lsu_st_data,
  output logic              o_lsu_wren,
  output logic [2:0]        o_lsu_funct3,
  input  logic [DATA_W-1:0] i_lsu_ld_data,
  output logic              o_busy,
  output logic              o_owner
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  localparam int             BW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0]  BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [2:0]     F3_WORD    = 3'b010;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner;
  logic              r_ptr;
  logic [BW-1:0]     r_burst;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [DATA_W-1:0] r_cmd_wdata;
  logic              r_cmd_we;
  logic              r_cmd_lock;
  logic [2:0]        r_cmd_f3;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;

  logic w_any;
  logic w_keep;
  logic w_ptr;
  logic w_win;
  logic w_arb;

  // In RESP the pointer is resolved from the access just finished, so a locked
  // burst keeps priority only while its owner is still requesting.
  always_comb begin
    w_any  = i_m0_req | i_m1_req;
    w_keep = r_cmd_lock && (r_burst < BURST_LAST) && (r_owner ? i_m1_req : i_m0_req);
    w_ptr  = r_ptr;
    if (r_state == S_RESP) begin
      w_ptr = w_keep ? r_owner : ~r_owner;
    end
    w_win  = (i_m0_req && i_m1_req) ? w_ptr : i_m1_req;
    w_arb  = w_any && (r_state != S_ACCESS);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    o_m0_gnt      = 1'b0;
    o_m1_gnt      = 1'b0;
    o_m0_ack      = 1'b0;
    o_m1_ack      = 1'b0;
    o_lsu_addr    = '0;
    o_lsu_st_data = '0;
    o_lsu_wren    = 1'b0;
    o_lsu_funct3  = F3_WORD;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        w_state_nxt   = S_RESP;
        o_m0_gnt      = ~r_owner;
        o_m1_gnt      = r_owner;
        o_lsu_addr    = r_cmd_addr;
        o_lsu_st_data = r_cmd_wdata;
        o_lsu_wren    = r_cmd_we & ~i_rst;
        o_lsu_funct3  = r_cmd_f3;
      end
      S_RESP: begin
        w_state_nxt = w_any ? S_ACCESS : S_IDLE;
        o_m0_ack    = ~r_owner & ~i_rst;
        o_m1_ack    = r_owner & ~i_rst;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner     <= 1'b0;
      r_ptr       <= 1'b0;
      r_burst     <= '0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_cmd_we    <= 1'b0;
      r_cmd_lock  <= 1'b0;
      r_cmd_f3    <= F3_WORD;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      if (w_arb) begin
        r_owner     <= w_win;
        r_cmd_addr  <= w_win ? i_m1_addr   : i_m0_addr;
        r_cmd_wdata <= w_win ? i_m1_wdata  : i_m0_wdata;
        r_cmd_we    <= w_win ? i_m1_we     : i_m0_we;
        r_cmd_lock  <= w_win ? i_m1_lock   : i_m0_lock;
        r_cmd_f3    <= w_win ? i_m1_funct3 : i_m0_funct3;
      end
      if (r_state == S_RESP) begin
        r_ptr   <= w_ptr;
        r_burst <= w_keep ? r_burst + BW'(1) : '0;
      end
      if ((r_state == S_ACCESS) && !r_cmd_we) begin
        if (r_owner) r_m1_rdata <= i_lsu_ld_data;
        else         r_m0_rdata <= i_lsu_ld_data;
      end
    end
  end

  assign o_m0_rdata = r_m0_rdata;
  assign o_m1_rdata = r_m1_rdata;
  assign o_busy     = (r_state != S_IDLE);
  assign o_owner    = r_owner;

endmodule
